axis_bram_reader: RTL and testbench



---
 rtl/axis_bram_adapter_pkg.sv | 18 +
 rtl/axis_bram_reader_fifo.sv | 53 +++++
 rtl/axis_bram_reader.sv | 112 +++++++++++
 tb/tb_axis_bram_reader.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_bram_adapter_pkg.sv
// Shared definitions for the BRAM-to-AXIS adapter:
// reader FSM encoding, buffer depth and address stepping.
package axis_bram_adapter_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_READ   = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    localparam int BUF_DEPTH = 4;

    function automatic int unsigned addr_incr(
        input int unsigned data_width
    );
        return data_width / 8;
    endfunction

endpackage

// File: rtl/axis_bram_reader_fifo.sv
// Four-entry sync FIFO holding read words and their last tag;
// push and pop may happen in the same cycle.
module axis_bram_reader_fifo
    import axis_bram_adapter_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         push_last,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         head_last,
    output logic [2:0]   count
);

    logic [W-1:0]           data_q [BUF_DEPTH];
    logic [BUF_DEPTH-1:0]   last_q;
    logic [1:0]             wr_ptr;
    logic [1:0]             rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                data_q[i] <= '0;
            end
            last_q <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                data_q[wr_ptr] <= push_data;
                last_q[wr_ptr] <= push_last;
                wr_ptr         <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = data_q[rd_ptr];
    assign head_last = last_q[rd_ptr];

endmodule

// File: rtl/axis_bram_reader.sv
// Streams a contiguous BRAM word range onto the user handshake;
// a small buffer hides the one-cycle BRAM read latency.
module axis_bram_reader
    import axis_bram_adapter_pkg::*;
#(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int C_BRAM_ADDR_WIDTH    = 32,
    parameter int C_LEN_WIDTH          = 16
) (
    input  logic                              M_AXIS_ACLK,
    input  logic                              M_AXIS_ARESET,
    input  logic                              START,
    input  logic [C_BRAM_ADDR_WIDTH-1:0]      BASE_ADDR,
    input  logic [C_LEN_WIDTH-1:0]            LEN,
    output logic                              BUSY,
    output logic                              DONE,
    output logic [C_BRAM_ADDR_WIDTH-1:0]      BRAM_ADDR,
    output logic                              BRAM_EN,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] BRAM_WE,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   BRAM_DOUT,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]   DOUT_DATA,
    output logic                              DOUT_VALID,
    output logic                              DOUT_TLAST,
    input  logic                              DOUT_ACCEP
);

    localparam logic [C_BRAM_ADDR_WIDTH-1:0] ADDR_INC =
        C_BRAM_ADDR_WIDTH'(addr_incr(C_M_AXIS_TDATA_WIDTH));

    logic [1:0]                   state;
    logic [C_BRAM_ADDR_WIDTH-1:0] addr_q;
    logic [C_LEN_WIDTH-1:0]       len_q;
    logic [C_LEN_WIDTH-1:0]       issued;
    logic                         pend;
    logic                         pend_last;
    logic [2:0]                   count;
    logic [2:0]                   occ;
    logic                         head_last;
    logic                         rd_en;
    logic                         rd_last;
    logic                         pop;

    // Reads in flight count against capacity so a stall can never overflow.
    assign occ     = count + {2'b00, pend};
    assign rd_last = (issued == len_q - C_LEN_WIDTH'(1));
    assign rd_en   = (state == S_READ) && (issued < len_q)
                   && (occ < 3'(BUF_DEPTH));

    assign DOUT_VALID = (count != 3'd0);
    assign DOUT_TLAST = head_last;
    assign pop        = DOUT_VALID && DOUT_ACCEP;

    assign BRAM_EN   = rd_en;
    assign BRAM_ADDR = addr_q;
    assign BRAM_WE   = '0;
    assign BUSY      = (state != S_IDLE);
    assign DONE      = (state == S_FINISH);

    always_ff @(posedge M_AXIS_ACLK) begin
        if (M_AXIS_ARESET) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            issued    <= '0;
            pend      <= 1'b0;
            pend_last <= 1'b0;
        end else begin
            pend      <= rd_en;
            pend_last <= rd_en && rd_last;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        addr_q <= BASE_ADDR;
                        len_q  <= LEN;
                        issued <= '0;
                        state  <= (LEN == '0) ? S_FINISH : S_READ;
                    end
                end
                S_READ: begin
                    if (rd_en) begin
                        addr_q <= addr_q + ADDR_INC;
                        issued <= issued + C_LEN_WIDTH'(1);
                        if (rd_last) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop && head_last) begin
                        state <= S_FINISH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    axis_bram_reader_fifo #(
        .W(C_M_AXIS_TDATA_WIDTH)
    ) u_fifo (
        .clk       (M_AXIS_ACLK),
        .rst       (M_AXIS_ARESET),
        .push      (pend),
        .push_data (BRAM_DOUT),
        .push_last (pend_last),
        .pop       (pop),
        .head_data (DOUT_DATA),
        .head_last (head_last),
        .count     (count)
    );

endmodule

// File: tb/tb_axis_bram_reader.sv
// Randomised bench for axis_bram_reader against a queue-based
// model of the expected word stream and cycle timing.
module tb_axis_bram_reader;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic [AW-1:0] bram_addr;
    logic          bram_en;
    logic [DW/8-1:0] bram_we;
    logic [DW-1:0] bram_dout;
    logic [DW-1:0] dout_data;
    logic          dout_valid;
    logic          dout_tlast;
    logic          dout_accep;

    logic [DW-1:0] mem [256];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_mode = 0;

    logic [DW-1:0] b_data [$];
    logic          b_last [$];
    int            b_cyc  [$];
    logic [AW-1:0] a_q    [$];
    int done_cyc, done_cnt, en_total, pop_total, max_ahead;
    logic st_valid, st_en;
    int st_occ;

    always #5 clk = ~clk;

    axis_bram_reader #(
        .C_M_AXIS_TDATA_WIDTH(DW),
        .C_BRAM_ADDR_WIDTH   (AW),
        .C_LEN_WIDTH         (LW)
    ) dut (
        .M_AXIS_ACLK  (clk),
        .M_AXIS_ARESET(rst),
        .START        (start),
        .BASE_ADDR    (base),
        .LEN          (len),
        .BUSY         (busy),
        .DONE         (done),
        .BRAM_ADDR    (bram_addr),
        .BRAM_EN      (bram_en),
        .BRAM_WE      (bram_we),
        .BRAM_DOUT    (bram_dout),
        .DOUT_DATA    (dout_data),
        .DOUT_VALID   (dout_valid),
        .DOUT_TLAST   (dout_tlast),
        .DOUT_ACCEP   (dout_accep)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bram_en) bram_dout <= mem[bram_addr[9:2]];
    end

    always @(posedge clk) begin
        #1;
        case (acc_mode)
            0: dout_accep = 1'b1;
            1: dout_accep = ~dout_accep;
            2: dout_accep = 1'($urandom_range(0, 1));
            default: dout_accep = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (bram_en) begin
            a_q.push_back(bram_addr);
            en_total++;
            if (en_total - pop_total > max_ahead)
                max_ahead = en_total - pop_total;
        end
        if (dout_valid && dout_accep) begin
            b_data.push_back(dout_data);
            b_last.push_back(dout_tlast);
            b_cyc.push_back(cyc);
            pop_total++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    function automatic logic [DW-1:0] ref_word(
        input logic [AW-1:0] b, input int k
    );
        logic [7:0] idx;
        idx = 8'((b >> 2) + AW'(k));
        return mem[idx];
    endfunction

    task automatic clear_mon();
        b_data.delete();
        b_last.delete();
        b_cyc.delete();
        a_q.delete();
        done_cyc = -1;
        done_cnt = 0;
        en_total = 0;
        pop_total = 0;
        max_ahead = 0;
    endtask

    task automatic run_xfer(
        input logic [AW-1:0] b, input int n,
        input bit extra, input bit stall,
        output int c0, output bit seen
    );
        bit stalled;
        stalled = 0;
        @(posedge clk); #2;
        clear_mon();
        base = b;
        len = LW'(n);
        start = 1'b1;
        c0 = cyc;
        seen = 0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(posedge clk); #2;
            start = 1'b0;
            if (extra && i == 1) begin
                start = 1'b1;
                base = 32'h100;
                len = 16'd5;
            end
            if (stall && !stalled && pop_total >= 3) begin
                acc_mode = 3;
                repeat (20) @(posedge clk);
                @(negedge clk);
                st_valid = dout_valid;
                st_en = bram_en;
                st_occ = en_total - pop_total;
                acc_mode = 0;
                stalled = 1;
                @(posedge clk); #2;
            end
            seen = (done_cnt > 0);
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++;
            $display("FAIL rst_done got %b want 0", done); end
        checks++; if (bram_en !== 1'b0) begin errors++;
            $display("FAIL rst_en got %b want 0", bram_en); end
        checks++; if (bram_addr !== '0) begin errors++;
            $display("FAIL rst_addr got %h want 0", bram_addr); end
        checks++; if (bram_we !== '0) begin errors++;
            $display("FAIL rst_we got %h want 0", bram_we); end
        checks++; if (dout_valid !== 1'b0) begin errors++;
            $display("FAIL rst_valid got %b want 0", dout_valid); end
        checks++; if (dout_data !== '0) begin errors++;
            $display("FAIL rst_data got %h want 0", dout_data); end
        checks++; if (dout_tlast !== 1'b0) begin errors++;
            $display("FAIL rst_tlast got %b want 0", dout_tlast); end
    endtask

    task automatic test_basic();
        int c0;
        bit seen;
        for (int i = 0; i < 256; i++) mem[i] = DW'(i);
        acc_mode = 0;
        run_xfer(32'h0, 8, 0, 0, c0, seen);
        checks++; if (!seen) begin errors++;
            $display("FAIL basic_done_timeout got 0 want 1"); end
        checks++; if (b_data.size() != 8) begin errors++;
            $display("FAIL basic_beats got %0d want 8", b_data.size()); end
        for (int k = 0; k < b_data.size() && k < 8; k++) begin
            checks++; if (b_data[k] !== DW'(k)) begin errors++;
                $display("FAIL basic_data[%0d] got %h want %h", k, b_data[k], k); end
            checks++; if (b_last[k] !== (k == 7)) begin errors++;
                $display("FAIL basic_last[%0d] got %b", k, b_last[k]); end
            checks++; if (b_cyc[k] != c0 + 3 + k) begin errors++;
                $display("FAIL basic_cyc[%0d] got %0d want %0d",
                         k, b_cyc[k] - c0, 3 + k); end
        end
        checks++; if (done_cyc != c0 + 11) begin errors++;
            $display("FAIL basic_done_cyc got %0d want 11", done_cyc - c0); end
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL basic_busy_end got %b want 0", busy); end
    endtask

    task automatic test_toggle();
        int c0;
        bit seen;
        acc_mode = 1;
        run_xfer(32'h0, 8, 1, 0, c0, seen);
        checks++; if (!seen || done_cnt != 1) begin errors++;
            $display("FAIL toggle_done got %0d want 1", done_cnt); end
        checks++; if (b_data.size() != 8) begin errors++;
            $display("FAIL toggle_beats got %0d want 8", b_data.size()); end
        for (int k = 0; k < b_data.size() && k < 8; k++) begin
            checks++; if (b_data[k] !== DW'(k)) begin errors++;
                $display("FAIL toggle_data[%0d] got %h want %h", k, b_data[k], k); end
        end
        checks++; if (max_ahead > 4) begin errors++;
            $display("FAIL toggle_ahead got %0d want <=4", max_ahead); end
        checks++; if (a_q.size() != 8) begin errors++;
            $display("FAIL toggle_reads got %0d want 8", a_q.size()); end
    endtask

    task automatic test_len0();
        int c0;
        bit seen;
        acc_mode = 0;
        run_xfer(32'h20, 0, 0, 0, c0, seen);
        checks++; if (!seen || done_cyc != c0 + 1) begin errors++;
            $display("FAIL len0_done_cyc got %0d want 1", done_cyc - c0); end
        checks++; if (a_q.size() != 0) begin errors++;
            $display("FAIL len0_reads got %0d want 0", a_q.size()); end
        checks++; if (b_data.size() != 0) begin errors++;
            $display("FAIL len0_beats got %0d want 0", b_data.size()); end
    endtask

    task automatic test_len1();
        int c0;
        bit seen;
        acc_mode = 0;
        run_xfer(32'h10, 1, 0, 0, c0, seen);
        checks++; if (b_data.size() != 1) begin errors++;
            $display("FAIL len1_beats got %0d want 1", b_data.size()); end
        if (b_data.size() > 0) begin
            checks++; if (b_data[0] !== 32'd4 || b_last[0] !== 1'b1) begin
                errors++;
                $display("FAIL len1_beat got %h/%b want 4/1", b_data[0], b_last[0]);
            end
        end
        checks++; if (!seen || done_cyc != c0 + 4) begin errors++;
            $display("FAIL len1_done_cyc got %0d want 4", done_cyc - c0); end
    endtask

    task automatic test_stall();
        int c0;
        bit seen;
        acc_mode = 0;
        run_xfer(32'h0, 16, 0, 1, c0, seen);
        checks++; if (st_valid !== 1'b1 || st_en !== 1'b0) begin errors++;
            $display("FAIL stall_sig got v%b en%b want v1 en0", st_valid, st_en); end
        checks++; if (st_occ != 4) begin errors++;
            $display("FAIL stall_occ got %0d want 4", st_occ); end
        checks++; if (b_data.size() != 16 || !seen) begin errors++;
            $display("FAIL stall_beats got %0d want 16", b_data.size()); end
        for (int k = 0; k < b_data.size() && k < 16; k++) begin
            checks++; if (b_data[k] !== DW'(k)) begin errors++;
                $display("FAIL stall_data[%0d] got %h want %h", k, b_data[k], k); end
        end
        for (int k = 0; k < a_q.size(); k++) begin
            checks++; if (a_q[k] !== AW'(4 * k)) begin errors++;
                $display("FAIL stall_addr[%0d] got %h want %h", k, a_q[k], 4 * k); end
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        bit seen;
        for (int i = 0; i < 256; i++) mem[i] = DW'(i);
        acc_mode = 0;
        @(posedge clk); #2;
        clear_mon();
        base = '0;
        len = 16'd8;
        start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        for (int i = 0; i < 100 && pop_total < 3; i++) @(posedge clk);
        checks++; if (pop_total < 3) begin errors++;
            $display("FAIL rmid_progress got %0d want 3", pop_total); end
        #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || dout_valid !== 1'b0) begin errors++;
            $display("FAIL rmid_clear got b%b v%b want 0", busy, dout_valid); end
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        run_xfer(32'h40, 2, 0, 0, c0, seen);
        checks++; if (b_data.size() != 2) begin errors++;
            $display("FAIL rmid_beats got %0d want 2", b_data.size()); end
        for (int k = 0; k < b_data.size() && k < 2; k++) begin
            checks++; if (b_data[k] !== mem[16 + k] || b_last[k] !== (k == 1)) begin
                errors++;
                $display("FAIL rmid_data[%0d] got %h want %h",
                         k, b_data[k], mem[16 + k]);
            end
        end
        checks++; if (!seen || done_cyc != c0 + 5) begin errors++;
            $display("FAIL rmid_done_cyc got %0d want 5", done_cyc - c0); end
    endtask

    task automatic test_random();
        int c0, n;
        bit seen;
        logic [AW-1:0] b;
        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < 256; i++) mem[i] = $urandom;
            b = AW'($urandom_range(0, 255) * 4);
            n = $urandom_range(0, 12);
            if (it == 0) begin b = 32'hFFFF_FFF8; n = 4; end
            acc_mode = (it % 3 == 0) ? 0 : 2;
            run_xfer(b, n, n > 0, 0, c0, seen);
            checks++; if (!seen || done_cnt != 1) begin errors++;
                $display("FAIL rnd%0d_done got %0d want 1", it, done_cnt); end
            checks++; if (b_data.size() != n || a_q.size() != n) begin errors++;
                $display("FAIL rnd%0d_beats got %0d/%0d want %0d",
                         it, b_data.size(), a_q.size(), n); end
            for (int k = 0; k < b_data.size() && k < n; k++) begin
                checks++;
                if (b_data[k] !== ref_word(b, k) || b_last[k] !== (k == n - 1)) begin
                    errors++;
                    $display("FAIL rnd%0d_data[%0d] got %h want %h",
                             it, k, b_data[k], ref_word(b, k));
                end
            end
            for (int k = 0; k < a_q.size() && k < n; k++) begin
                checks++; if (a_q[k] !== b + AW'(4 * k)) begin errors++;
                    $display("FAIL rnd%0d_addr[%0d] got %h want %h",
                             it, k, a_q[k], b + AW'(4 * k)); end
            end
            checks++; if (max_ahead > 4) begin errors++;
                $display("FAIL rnd%0d_ahead got %0d want <=4", it, max_ahead); end
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        base = '0;
        len = '0;
        dout_accep = 1'b0;
        bram_dout = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        clear_mon();
        test_reset();
        test_basic();
        test_toggle();
        test_len0();
        test_len1();
        test_stall();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
